// File: rtl/uart_tx_queue_pkg.sv
// Shared UART types: transmitter and transmit-queue state encodings.
// Imported by the queue and its FIFO.
package uart_tx_queue_pkg;

  typedef enum logic [1:0] {
    TIdle,
    TStart,
    TData,
    TStop
  } TxState;

  typedef enum logic [1:0] {
    QStart,
    QIdle,
    QWait
  } TxQState;

  localparam int ByteW = 8;

endpackage

// File: rtl/uart_tx_queue_byte_fifo.sv
// Power-of-two byte FIFO with registered count, full, empty and
// a sticky overflow flag; asynchronous read port.
module byte_fifo
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     sourceClk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ByteW-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [ByteW-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ByteW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push;
  logic             pop;

  // full/empty are pre-edge values, so a push into a full queue is
  // dropped even when a pop happens on the same edge
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_ff @(posedge sourceClk) begin
    if (reset && push)
      mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
      if (wr_en && full)
        overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit queue: buffers bytes and issues them one at a time to the
// UART transmitter with an active-low tx_en pulse.
module uart_tx_queue
  import uart_tx_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   sourceClk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [ByteW-1:0]       wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   busy,
  output logic                   tx_en,
  output logic [ByteW-1:0]       tx_byte,
  input  logic                   tx_complete
);

  TxQState          state;
  logic             start_cnt;
  logic             issue;
  logic [ByteW-1:0] rd_data;

  assign issue = (state == QIdle) && !empty;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .sourceClk (sourceClk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .rd_en     (issue),
    .rd_data   (rd_data),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow)
  );

  always_ff @(posedge sourceClk) begin
    if (!reset) begin
      state     <= QStart;
      start_cnt <= 1'b0;
      tx_en     <= 1'b1;
      tx_byte   <= '0;
      busy      <= 1'b0;
    end else begin
      tx_en <= 1'b1;
      unique case (state)
        // give the transmitter two cycles to leave its own reset
        QStart: begin
          start_cnt <= ~start_cnt;
          if (start_cnt)
            state <= QIdle;
        end
        QIdle: begin
          if (!empty) begin
            tx_en   <= 1'b0;
            tx_byte <= rd_data;
            busy    <= 1'b1;
            state   <= QWait;
          end
        end
        QWait: begin
          if (tx_complete) begin
            busy  <= 1'b0;
            state <= QIdle;
          end
        end
        default: state <= QStart;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Randomized bench for uart_tx_queue with a behavioural
// transmitter that records every issued byte.
module tb_uart_tx_queue;

  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          sourceClk;
  logic          reset;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          busy;
  logic          tx_en;
  logic [7:0]    tx_byte;
  logic          tx_complete;

  int checks = 0;
  int errors = 0;

  uart_tx_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .sourceClk   (sourceClk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .busy        (busy),
    .tx_en       (tx_en),
    .tx_byte     (tx_byte),
    .tx_complete (tx_complete)
  );

  initial begin
    sourceClk = 1'b0;
    forever #5 sourceClk = ~sourceClk;
  end

  // transmitter model state
  int         cyc = 0;
  logic       mon_r;
  bit         hold = 0;
  int         tx_delay = 1;
  bit         inflight = 0;
  bit         pending = 0;
  int         cd = 0;
  int         viol = 0;
  logic [7:0] sent_q[$];
  int         issue_q[$];
  int         raise_q[$];

  initial tx_complete = 1'b0;

  always @(posedge sourceClk) begin
    mon_r = reset;
    cyc++;
    #2;
    if (!mon_r) begin
      inflight    = 0;
      pending     = 0;
      tx_complete = 1'b0;
    end else begin
      if (tx_complete)
        inflight = 0;
      tx_complete = 1'b0;
      if (tx_en === 1'b0) begin
        if (inflight)
          viol++;
        inflight = 1;
        pending  = 1;
        cd       = tx_delay;
        sent_q.push_back(tx_byte);
        issue_q.push_back(cyc);
      end else begin
        if (inflight && tx_byte !== sent_q[$])
          viol++;
        if (pending && !hold) begin
          cd--;
          if (cd <= 0) begin
            tx_complete = 1'b1;
            pending     = 0;
            raise_q.push_back(cyc);
          end
        end
      end
      if (busy !== inflight)
        viol++;
    end
  end

  task automatic tick();
    @(posedge sourceClk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    wr_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_drain(input int max, output bit ok);
    int n = 0;
    while ((empty !== 1'b1 || busy !== 1'b0 || tx_en !== 1'b1) && n < max) begin
      tick();
      n++;
    end
    ok = (n < max);
  endtask

  task automatic test_reset();
    int lows = 0;
    reset = 1'b0;
    tick();
    tick();
    checks++;
    if ({tx_en, empty, full, overflow, busy} !== 5'b11000) begin
      errors++;
      $display("FAIL rst_flags got %b want 11000",
               {tx_en, empty, full, overflow, busy});
    end
    checks++;
    if (count !== '0 || tx_byte !== 8'h00) begin
      errors++;
      $display("FAIL rst_vals got count=%0d byte=%h want 0 00",
               count, tx_byte);
    end
    reset = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_en !== 1'b1)
        lows++;
    end
    checks++;
    if (lows != 0) begin
      errors++;
      $display("FAIL idle_tx_en got %0d low cycles want 0", lows);
    end
    checks++;
    if (empty !== 1'b1 || count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL idle_state got e=%b c=%0d o=%b want 1 0 0",
               empty, count, overflow);
    end
  endtask

  task automatic test_single();
    int n = 0;
    tx_delay = 100;
    wr_en    = 1'b1;
    wr_data  = 8'hA5;
    tick();
    wr_en = 1'b0;
    checks++;
    if (count !== CW'(1) || empty !== 1'b0 || tx_en !== 1'b1) begin
      errors++;
      $display("FAIL single_push got c=%0d e=%b en=%b want 1 0 1",
               count, empty, tx_en);
    end
    tick();
    checks++;
    if (tx_en !== 1'b0 || tx_byte !== 8'hA5 || count !== '0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_issue got en=%b b=%h c=%0d busy=%b want 0 a5 0 1",
               tx_en, tx_byte, count, busy);
    end
    while (busy === 1'b1 && n < 300) begin
      n++;
      tick();
    end
    checks++;
    if (n != 101) begin
      errors++;
      $display("FAIL single_busy_span got %0d want 101", n);
    end
    checks++;
    if (tx_byte !== 8'hA5) begin
      errors++;
      $display("FAIL single_hold got %h want a5", tx_byte);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp[3] = '{8'h01, 8'h02, 8'h03};
    int  b0 = sent_q.size();
    int  r0 = raise_q.size();
    bit  ok;
    tx_delay = 20;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = exp[i];
      tick();
    end
    wr_en = 1'b0;
    wait_drain(500, ok);
    checks++;
    if (!ok || sent_q.size() != b0 + 3) begin
      errors++;
      $display("FAIL b2b_count got %0d sent want 3", sent_q.size() - b0);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (sent_q[b0+i] !== exp[i]) begin
          errors++;
          $display("FAIL b2b_order[%0d] got %h want %h",
                   i, sent_q[b0+i], exp[i]);
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (issue_q[b0+i] - raise_q[r0+i-1] != 2) begin
          errors++;
          $display("FAIL b2b_gap[%0d] got %0d want 2",
                   i, issue_q[b0+i] - raise_q[r0+i-1]);
        end
      end
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] d[18];
    int  b0 = sent_q.size();
    bit  ok;
    hold = 1;
    for (int i = 0; i < 18; i++) begin
      d[i]    = 8'($urandom);
      wr_en   = 1'b1;
      wr_data = d[i];
      tick();
      if (i == 16) begin
        checks++;
        if (full !== 1'b1 || count !== CW'(16) || overflow !== 1'b0) begin
          errors++;
          $display("FAIL full_set got f=%b c=%0d o=%b want 1 16 0",
                   full, count, overflow);
        end
      end
    end
    wr_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== CW'(16) || busy !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set got o=%b c=%0d busy=%b want 1 16 1",
               overflow, count, busy);
    end
    tx_delay = int'($urandom_range(1, 5));
    hold     = 0;
    wait_drain(2000, ok);
    checks++;
    if (!ok || sent_q.size() != b0 + 17) begin
      errors++;
      $display("FAIL full_drain got %0d sent want 17", sent_q.size() - b0);
    end else begin
      for (int i = 0; i < 17; i++) begin
        checks++;
        if (sent_q[b0+i] !== d[i]) begin
          errors++;
          $display("FAIL full_order[%0d] got %h want %h",
                   i, sent_q[b0+i], d[i]);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || full !== 1'b0) begin
      errors++;
      $display("FAIL overflow_sticky got o=%b f=%b want 1 0", overflow, full);
    end
  endtask

  task automatic test_wrap();
    int b0;
    bit ok;
    do_reset();
    b0 = sent_q.size();
    for (int b = 0; b < 4; b++) begin
      tx_delay = int'($urandom_range(1, 8));
      for (int i = 0; i < 10; i++) begin
        wr_en   = 1'b1;
        wr_data = 8'(b * 10 + i);
        tick();
      end
      wr_en = 1'b0;
      wait_drain(1000, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL wrap_drain burst %0d got timeout want drained", b);
      end
    end
    checks++;
    if (sent_q.size() != b0 + 40) begin
      errors++;
      $display("FAIL wrap_count got %0d sent want 40", sent_q.size() - b0);
    end else begin
      for (int i = 0; i < 40; i++) begin
        checks++;
        if (sent_q[b0+i] !== 8'(i)) begin
          errors++;
          $display("FAIL wrap_order[%0d] got %h want %h",
                   i, sent_q[b0+i], 8'(i));
        end
      end
    end
    checks++;
    if (count !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL wrap_end got c=%0d o=%b want 0 0", count, overflow);
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    bit ok;
    do_reset();
    tick();
    tick();
    hold = 1;
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 8'($urandom);
      tick();
    end
    wr_en = 1'b0;
    checks++;
    if (count !== CW'(5) || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup got c=%0d busy=%b want 5 1", count, busy);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (count !== '0 || tx_en !== 1'b1 || busy !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset got c=%0d en=%b busy=%b e=%b want 0 1 0 1",
               count, tx_en, busy, empty);
    end
    reset    = 1'b1;
    hold     = 0;
    tx_delay = 3;
    s0       = sent_q.size();
    repeat (30) tick();
    checks++;
    if (sent_q.size() != s0) begin
      errors++;
      $display("FAIL mid_no_issue got %0d sent want 0", sent_q.size() - s0);
    end
    wr_en   = 1'b1;
    wr_data = 8'h5A;
    tick();
    wr_en = 1'b0;
    wait_drain(200, ok);
    checks++;
    if (!ok || sent_q.size() != s0 + 1 || sent_q[$] !== 8'h5A) begin
      errors++;
      $display("FAIL mid_after got %0d sent last=%h want 1 5a",
               sent_q.size() - s0, sent_q[$]);
    end
  endtask

  initial begin
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_overflow();
    test_wrap();
    test_reset_mid();
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL protocol got %0d violations want 0", viol);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Byte queue sitting directly upstream of the UART transmitter. Accepts bytes from the system side through a single-cycle write strobe, buffers them in a power-of-two FIFO, and feeds them one at a time to the transmitter. It drives the transmitter's active-low `tx_en` with a one-cycle pulse and holds `tx_byte` stable. It waits for the transmitter's `tx_complete` pulse before issuing the next byte.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, minimum 2.
- `sourceClk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  active-high write strobe; pushes `wr_data` on this edge unless `full`.
- `wr_data`  in  8  byte to enqueue.
- `full`  out  1  registered; `count == DEPTH`.
- `empty`  out  1  registered; `count == 0`.
- `count`  out  $clog2(DEPTH)+1  bytes stored, not including the byte in flight.
- `overflow`  out  1  sticky; set when `wr_en` arrives while `full`; cleared only by reset.
- `busy`  out  1  high from `tx_en` assertion until `tx_complete` is received.
- `tx_en`  out  1  to transmitter; active low, one-cycle pulse.
- `tx_byte`  out  8  to transmitter; stable from the `tx_en` pulse until `tx_complete`.
- `tx_complete`  in  1  from transmitter; one-cycle high pulse at the end of the stop bit(s).

## Operation
- **Reset values**, while `reset` = 0 and on the edge it is sampled low:
  - Read and write pointers, `count`, `overflow`, `busy`: 0.
  - `tx_byte`: 0x00.
  - `tx_en`: 1, `empty`: 1, `full`: 0.
  - State: QStart.
- **States:**
  - QStart: holds 2 cycles, counted by a 1-bit counter, so the transmitter can pass through its own reset state. Then goes to QIdle.
  - QIdle: if `!empty`:
    - Drive `tx_en` = 0 and `tx_byte` = `mem[rd_ptr]`.
    - Increment `rd_ptr` and decrement `count`.
    - Set `busy` = 1 and go to QWait.
  - QWait: `tx_en` = 1. On `tx_complete` = 1, set `busy` = 0 and go to QIdle.
- **Write rules:**
  - Writes are accepted in every state except during reset, including QStart.
  - On an accepted write: `mem[wr_ptr]` = `wr_data`, `wr_ptr`+1, `count`+1.
- **Pointers:** width $clog2(DEPTH) and wrap modulo DEPTH. `count` is the authoritative full/empty source; the pointers are never compared.
- **Simultaneous push and pop (QIdle issuing):**
  - `count` is unchanged and both pointers advance.
  - If `full` was 1, the push is dropped and `overflow` is set; `full` is evaluated on the pre-edge value.
  - If `empty` was 1, no pop occurs; the pushed byte issues on a later cycle.
- **`tx_complete` outside QWait:** ignored.
- **Reset mid-transfer:** the queue is flushed and the in-flight byte is abandoned. The transmitter shares `reset`, so no handshake state survives.

## Timing
- Write at edge k into an empty, idle queue:
  - `count` = 1 and `empty` = 0 after edge k.
  - `tx_en` low for exactly one cycle after edge k+1; `count` returns to 0 at the same edge.
- Back-to-back: `tx_complete` sampled high at edge c → QIdle after edge c. The next `tx_en` pulse follows edge c+1, while the transmitter is back in its idle state.
- The `tx_en` low width is always exactly 1 cycle; it is never asserted while `busy` = 1.
- `full`, `empty` and `count` update on the same edge as the pointer change. No combinational paths from inputs to outputs.

## Structure
- A shared UART package holds the `TxQState` enum (QStart, QIdle, QWait) alongside the existing transmitter state type.
- Natural sub-module: `byte_fifo` (param DEPTH), containing the memory, pointers, count, full, empty and overflow. `uart_tx_queue` contains only the issue FSM.
- Memory is inferred as distributed RAM with registered read data captured into `tx_byte`.

## Test plan
- **Reset, then idle:** release `reset`; no writes for 50 cycles → `tx_en` stays 1, `empty` = 1, `count` = 0, `overflow` = 0.
- **Single byte:** write 0xA5 at edge k → `tx_en` low only in the cycle after edge k+1, and `tx_byte` = 0xA5 held until a `tx_complete` pulse, modelled 100 cycles later. `busy` is 1 for that span.
- **Ordering and back-to-back:** write 0x01, 0x02, 0x03 on consecutive edges, with the transmitter model completing after 20 cycles each → `tx_byte` sequence 0x01, 0x02, 0x03. Each new `tx_en` pulse comes 2 edges after the previous `tx_complete`.
- **Full and overflow:** with `tx_complete` withheld, write 18 bytes with DEPTH = 16:
  - First byte in flight, 16 stored, `full` = 1.
  - 18th write dropped, `overflow` = 1.
  - Draining yields bytes 1–17 in order.
- **Wrap-around:** push and drain 40 bytes 0x00–0x27 in bursts of 10 → all transmitted in order, `count` returns to 0.
- **Reset mid-operation:** assert `reset` during QWait with 5 bytes queued → next edge `count` = 0, `tx_en` = 1, `busy` = 0. After release, no byte issues until a new write.
